// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode and serializer state encodings.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } ser_state_e;

  // data_xor is the XOR of all payload bits; odd parity inverts it.
  function automatic logic parity_bit(parity_e mode, logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and a synchronous flush.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rd_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;
  logic             full_q;
  logic             empty_q;
  logic             push;
  logic             pop;

  // A pop in the same cycle frees a slot, so a write at full still lands.
  assign pop  = rd && !empty_q;
  assign push = wr && !flush && (!full_q || pop);

  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else if (push && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      level_q <= level_d;
      full_q  <= (level_d == (AW+1)'(DEPTH));
      empty_q <= (level_d == '0);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;

endmodule

// File: rtl/uart_txq.sv
// Queued UART transmitter: FIFO in front of a start/data/parity/stop serializer.
module uart_txq
  import uart_pkg::*;
#(
  parameter int      CLOCK_HZ  = 100_000,
  parameter int      BAUD      = 1_000,
  parameter int      DATA_BITS = 8,
  parameter parity_e PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1,
  parameter int      DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [DATA_BITS-1:0]     wr_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     tx
);

  localparam int                 DIV        = CLOCK_HZ / BAUD;
  localparam int                 CNT_W      = $clog2(DIV);
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(DIV - 1);
  localparam logic [3:0]         LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0]         LAST_STOP  = 4'(STOP_BITS - 1);

  ser_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [3:0]             bit_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   par_q;
  logic                   tx_q;
  logic                   busy_q;
  logic [DATA_BITS-1:0]   head;
  logic                   bit_end;
  logic                   pop;

  assign bit_end = (cnt_q == '0);
  // Pop from IDLE, or at the end of the last stop bit for back-to-back frames.
  assign pop = !empty &&
               ((state_q == IDLE) ||
                (state_q == STOP && bit_end && bit_q == LAST_STOP));

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .wr_data (wr_data),
    .rd      (pop),
    .rd_data (head),
    .flush   (flush),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else if (pop) begin
      state_q <= START;
      cnt_q   <= CNT_RELOAD;
      bit_q   <= '0;
      shreg_q <= head;
      par_q   <= parity_bit(PARITY, ^head);
      tx_q    <= 1'b0;
      busy_q  <= 1'b1;
    end else if (state_q != IDLE && !bit_end) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else begin
      case (state_q)
        IDLE: ;
        START: begin
          state_q <= DATA;
          cnt_q   <= CNT_RELOAD;
          tx_q    <= shreg_q[0];
          shreg_q <= shreg_q >> 1;
        end
        DATA: begin
          cnt_q <= CNT_RELOAD;
          if (bit_q == LAST_DATA) begin
            bit_q <= '0;
            if (PARITY == PAR_NONE) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              state_q <= PAR;
              tx_q    <= par_q;
            end
          end else begin
            bit_q   <= bit_q + 4'd1;
            tx_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
          end
        end
        PAR: begin
          state_q <= STOP;
          cnt_q   <= CNT_RELOAD;
          bit_q   <= '0;
          tx_q    <= 1'b1;
        end
        STOP: begin
          cnt_q <= CNT_RELOAD;
          if (bit_q == LAST_STOP) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            bit_q <= bit_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
